serial_receiver_ext: RTL and testbench
======================================

Name: serial_receiver_ext

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. Data width, parity mode and stop-bit count are configurable. Adds false-start rejection, parity checking, break detection and an asynchronous active-low reset. Sits between the board RXD pin and the byte-stream consumer in the same clock domain.

Parameters:
ClockFrequency, 16000000, top-level clock frequency in Hz
BaudRate, 115200, line rate; ClockFrequency/BaudRate must be >= 8
DataBits, 8, data bits per frame, legal 5..9
Parity, 0, 0 = none, 1 = odd, 2 = even
StopBits, 1, stop bits checked, legal 1 or 2

Ports:
iClock  in  1  top-level clock
iResetN  in  1  asynchronous active-low reset
iRXD  in  1  serial input, idle high, LSB first
oData  out  DataBits  last correctly framed word
oReceived  out  1  one-clock pulse: new word valid in oData
oParityError  out  1  one-clock pulse, coincident with oReceived, when the parity check fails
oFrameError  out  1  one-clock pulse: a stop bit sampled low
oBreak  out  1  one-clock pulse, coincident with oFrameError, when all data, parity and stop samples were 0

Behaviour:
- Reset is asynchronous and active-low. It is decided as one clock, async active-low reset, with iClock and iResetN.
- While iResetN=0: state=sIdle, all outputs 0, oData=0, timer and bit counter 0, 2-flop RXD synchroniser = 1.
- Deasserting iResetN mid-frame: that frame is discarded. Reception restarts at the next falling edge seen in sIdle.
- TicksPerBit = ClockFrequency/BaudRate (integer division). HalfBit = TicksPerBit/2.
- Timer is a down-counter, $clog2(TicksPerBit) bits wide.
- All sampling uses the synchronised RXD, which is 2 clocks behind iRXD.
- States and transitions:
  - sIdle: wait for synchronised RXD = 0, then load timer with HalfBit-1 and go to sStartCheck.
  - sStartCheck: at timer = 0, sample the line. Sample 1 = false start: go to sIdle with no pulses. Sample 0: load TicksPerBit-1 and go to sData.
  - sData: at each timer expiry, shift the sample into the MSB of the shift register and increment the bit counter. After DataBits samples, go to sParity if Parity != 0, else go to sStop.
  - sParity: sample one bit. Error = XOR of data bits and parity bit is 0 for odd, 1 for even.
  - sStop: sample StopBits stop bits, one bit period apart. Any stop sample of 0 ends the check immediately and goes to sRecover.
  - sRecover: wait for synchronised RXD = 1, then go to sIdle.
- Delivery on good stop bits: 1 clock after the mid-bit sample of the last stop bit, oData = shift register (bit 0 = first received bit) and oReceived = 1. oParityError = 1 in the same cycle if parity failed. Return to sIdle in that cycle.
- Frame error: oFrameError = 1 for one clock. oReceived stays 0 and oData is unchanged. oBreak = 1 in the same cycle if every data, parity and stop sample was 0.
- No back-pressure. oData holds until the next good frame overwrites it.
- Back-to-back frames: a new start edge is accepted in the cycle after return to sIdle, so no idle time is required after the stop bit.
- All output pulses are exactly one clock wide and are registered.

Optional Feature:
Macro SERIAL_RECEIVER_MAJORITY_VOTE_EN.
- Defined: every bit sample, start bit included, is the majority of the synchronised line at timer = 1, 0 and the cycle after. The next bit's timer load is offset so bit-to-bit spacing stays TicksPerBit. Any single-cycle glitch is rejected. Latency to oReceived grows by 1 clock.
- Undefined: single sample at timer = 0, as described in Behaviour.

Test Plan:
- 16 MHz / 1 MHz, 8N1: send 0xA5 -> oData=0xA5, oReceived single pulse ~152 clocks after the start edge; no error pulses.
- DataBits=7, Parity=2: send 0x41 with parity 0 -> oData=0x41, oReceived=1, oParityError=0. Send 0x41 with parity 1 -> oReceived=1 and oParityError=1 in the same cycle.
- 8N1: 3-clock low glitch on an idle line -> no output pulse, state returns to sIdle. With the macro defined, a 1-clock glitch at mid-data-bit leaves the received byte correct.
- 8N1: line held low for 12 bit times, then high -> oFrameError=1 and oBreak=1 in the same cycle, oReceived never asserted, oData unchanged. The next frame 0x3C is received correctly.
- StopBits=2: send 0x55 with the second stop bit low -> oFrameError=1, oBreak=0, oReceived=0.
- Assert iResetN=0 during data bit 4 of a frame -> all outputs 0 immediately. After release, the rest of that frame produces no oReceived, and the following frame 0x81 is received as 0x81.

Source files
------------

// File: rtl/serial_receiver_ext_if.sv
// Byte-stream side of serial_receiver_ext: serial input line plus the
// received word and its status pulses.
interface serial_receiver_ext_if #(
  parameter int DataBits = 8
);
  logic                iRXD;
  logic [DataBits-1:0] oData;
  logic                oReceived;
  logic                oParityError;
  logic                oFrameError;
  logic                oBreak;

  modport slave (
    input  iRXD,
    output oData, oReceived, oParityError, oFrameError, oBreak
  );

  modport master (
    output iRXD,
    input  oData, oReceived, oParityError, oFrameError, oBreak
  );
endinterface

// File: rtl/serial_receiver_ext.sv
// Parametrised UART receiver with parity, false-start rejection and break detection.
// Optional 3-sample majority voting per bit: define SERIAL_RECEIVER_MAJORITY_VOTE_EN.
module serial_receiver_ext #(
  parameter int ClockFrequency = 16000000,
  parameter int BaudRate       = 115200,
  parameter int DataBits       = 8,
  parameter int Parity         = 0,
  parameter int StopBits       = 1
) (
  input logic                  iClock,
  input logic                  iResetN,
  serial_receiver_ext_if.slave bus
);

  localparam int TicksPerBit = ClockFrequency / BaudRate;
  localparam int HalfBit     = TicksPerBit / 2;
  localparam int TimerW      = $clog2(TicksPerBit);
  localparam int ParityOdd   = 32'sd1;
  localparam int ParityEven  = 32'sd2;
`ifdef SERIAL_RECEIVER_MAJORITY_VOTE_EN
  // Decision lands one cycle after timer = 0, so reload one shorter to keep bit spacing.
  localparam logic [TimerW-1:0] BitLoad = TimerW'(TicksPerBit - 2);
`else
  localparam logic [TimerW-1:0] BitLoad = TimerW'(TicksPerBit - 1);
`endif
  localparam logic [TimerW-1:0] HalfLoad = TimerW'(HalfBit - 1);
  localparam logic [TimerW-1:0] TimerZero = {TimerW{1'b0}};
  localparam logic [3:0]        LastData = 4'(DataBits - 1);
  localparam logic [3:0]        LastStop = 4'(StopBits - 1);

  typedef enum logic [2:0] {
    sIdle       = 3'd0,
    sStartCheck = 3'd1,
    sData       = 3'd2,
    sParity     = 3'd3,
    sStop       = 3'd4,
    sRecover    = 3'd5
  } state_t;

  function automatic logic parity_fail(input logic [DataBits-1:0] data, input logic pbit);
    logic x;
    x = (^data) ^ pbit;
    case (Parity)
      ParityOdd:  return ~x;
      ParityEven: return x;
      default:    return 1'b0;
    endcase
  endfunction

  state_t              r_state, w_state_next;
  logic [1:0]          r_sync;
  logic [TimerW-1:0]   r_timer, w_timer_next;
  logic [3:0]          r_bitcnt, w_bitcnt_next;
  logic [DataBits-1:0] r_shift, w_shift_next;
  logic                r_par_err, w_par_err_next;
  logic                r_all_zero, w_all_zero_next;
  logic [DataBits-1:0] r_data, w_data_next;
  logic                r_received, w_received_next;
  logic                r_parity_error, w_parity_error_next;
  logic                r_frame_error, w_frame_error_next;
  logic                r_break, w_break_next;
  logic                w_rxd, w_counting, w_tick, w_bit;

  assign w_rxd      = r_sync[1];
  assign w_counting = (r_state == sStartCheck) || (r_state == sData) ||
                      (r_state == sParity) || (r_state == sStop);

`ifdef SERIAL_RECEIVER_MAJORITY_VOTE_EN
  logic [1:0] r_vote;
  logic       r_pending;

  // Captures the line at timer = 1 and 0; the vote completes with the following cycle.
  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      r_vote    <= 2'b11;
      r_pending <= 1'b0;
    end else begin
      if (r_timer == TimerW'(1)) r_vote[1] <= w_rxd;
      if (r_timer == TimerZero)  r_vote[0] <= w_rxd;
      r_pending <= w_counting && (r_timer == TimerZero) && !r_pending;
    end
  end

  assign w_tick = r_pending;
  assign w_bit  = (r_vote[1] & r_vote[0]) | (r_vote[1] & w_rxd) | (r_vote[0] & w_rxd);
`else
  assign w_tick = w_counting && (r_timer == TimerZero);
  assign w_bit  = w_rxd;
`endif

  // State, datapath and registered outputs.
  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      r_state        <= sIdle;
      r_sync         <= 2'b11;
      r_timer        <= TimerZero;
      r_bitcnt       <= 4'd0;
      r_shift        <= {DataBits{1'b0}};
      r_par_err      <= 1'b0;
      r_all_zero     <= 1'b0;
      r_data         <= {DataBits{1'b0}};
      r_received     <= 1'b0;
      r_parity_error <= 1'b0;
      r_frame_error  <= 1'b0;
      r_break        <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_sync         <= {r_sync[0], bus.iRXD};
      r_timer        <= w_timer_next;
      r_bitcnt       <= w_bitcnt_next;
      r_shift        <= w_shift_next;
      r_par_err      <= w_par_err_next;
      r_all_zero     <= w_all_zero_next;
      r_data         <= w_data_next;
      r_received     <= w_received_next;
      r_parity_error <= w_parity_error_next;
      r_frame_error  <= w_frame_error_next;
      r_break        <= w_break_next;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_next    = r_state;
    w_timer_next    = (r_timer != TimerZero) ? (r_timer - 1'b1) : r_timer;
    w_bitcnt_next   = r_bitcnt;
    w_shift_next    = r_shift;
    w_par_err_next  = r_par_err;
    w_all_zero_next = r_all_zero;
    case (r_state)
      sIdle: begin
        if (!w_rxd) begin
          w_state_next = sStartCheck;
          w_timer_next = HalfLoad;
        end else begin
          w_state_next = sIdle;
        end
      end
      sStartCheck: begin
        if (w_tick && w_bit) begin
          w_state_next = sIdle;
        end else if (w_tick) begin
          w_state_next    = sData;
          w_timer_next    = BitLoad;
          w_bitcnt_next   = 4'd0;
          w_par_err_next  = 1'b0;
          w_all_zero_next = 1'b1;
        end else begin
          w_state_next = sStartCheck;
        end
      end
      sData: begin
        if (w_tick) begin
          w_shift_next    = {w_bit, r_shift[DataBits-1:1]};
          w_all_zero_next = r_all_zero & ~w_bit;
          w_timer_next    = BitLoad;
          if (r_bitcnt == LastData) begin
            w_bitcnt_next = 4'd0;
            w_state_next  = (Parity != 0) ? sParity : sStop;
          end else begin
            w_bitcnt_next = r_bitcnt + 4'd1;
          end
        end else begin
          w_state_next = sData;
        end
      end
      sParity: begin
        if (w_tick) begin
          w_par_err_next  = parity_fail(r_shift, w_bit);
          w_all_zero_next = r_all_zero & ~w_bit;
          w_timer_next    = BitLoad;
          w_state_next    = sStop;
        end else begin
          w_state_next = sParity;
        end
      end
      sStop: begin
        if (w_tick && !w_bit) begin
          w_state_next = sRecover;
        end else if (w_tick && (r_bitcnt == LastStop)) begin
          w_state_next = sIdle;
        end else if (w_tick) begin
          w_all_zero_next = 1'b0;
          w_bitcnt_next   = r_bitcnt + 4'd1;
          w_timer_next    = BitLoad;
        end else begin
          w_state_next = sStop;
        end
      end
      sRecover: begin
        if (w_rxd) begin
          w_state_next = sIdle;
        end else begin
          w_state_next = sRecover;
        end
      end
      default: w_state_next = sIdle;
    endcase
  end

  // Output pulses, decided on the stop-bit sample.
  always_comb begin
    w_data_next         = r_data;
    w_received_next     = 1'b0;
    w_parity_error_next = 1'b0;
    w_frame_error_next  = 1'b0;
    w_break_next        = 1'b0;
    if ((r_state == sStop) && w_tick) begin
      if (!w_bit) begin
        w_frame_error_next = 1'b1;
        w_break_next       = r_all_zero;
      end else if (r_bitcnt == LastStop) begin
        w_data_next         = r_shift;
        w_received_next     = 1'b1;
        w_parity_error_next = r_par_err;
      end else begin
        w_received_next = 1'b0;
      end
    end else begin
      w_received_next = 1'b0;
    end
  end

  assign bus.oData        = r_data;
  assign bus.oReceived    = r_received;
  assign bus.oParityError = r_parity_error;
  assign bus.oFrameError  = r_frame_error;
  assign bus.oBreak       = r_break;

endmodule

// File: tb/tb_serial_receiver_ext.sv
// Directed bench for serial_receiver_ext: three instances (8N1, 7E1, 8N2) at 16 clocks per bit.
module tb_serial_receiver_ext;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rxd;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         start_cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  serial_receiver_ext_if #(.DataBits(8)) if0 ();
  serial_receiver_ext_if #(.DataBits(7)) if1 ();
  serial_receiver_ext_if #(.DataBits(8)) if2 ();

  assign if0.iRXD = rxd[0];
  assign if1.iRXD = rxd[1];
  assign if2.iRXD = rxd[2];

  serial_receiver_ext #(.ClockFrequency(16000000), .BaudRate(1000000), .DataBits(8),
                        .Parity(0), .StopBits(1))
    dut0 (.iClock(clk), .iResetN(rst_n), .bus(if0.slave));
  serial_receiver_ext #(.ClockFrequency(16000000), .BaudRate(1000000), .DataBits(7),
                        .Parity(2), .StopBits(1))
    dut1 (.iClock(clk), .iResetN(rst_n), .bus(if1.slave));
  serial_receiver_ext #(.ClockFrequency(16000000), .BaudRate(1000000), .DataBits(8),
                        .Parity(0), .StopBits(2))
    dut2 (.iClock(clk), .iResetN(rst_n), .bus(if2.slave));

  logic [2:0] rx_v, pe_v, fe_v, bk_v;
  assign rx_v = {if2.oReceived, if1.oReceived, if0.oReceived};
  assign pe_v = {if2.oParityError, if1.oParityError, if0.oParityError};
  assign fe_v = {if2.oFrameError, if1.oFrameError, if0.oFrameError};
  assign bk_v = {if2.oBreak, if1.oBreak, if0.oBreak};

  int rx_cnt[3]  = '{0, 0, 0};
  int pe_cnt[3]  = '{0, 0, 0};
  int fe_cnt[3]  = '{0, 0, 0};
  int bk_cnt[3]  = '{0, 0, 0};
  int pex_cnt[3] = '{0, 0, 0};
  int bkx_cnt[3] = '{0, 0, 0};
  int rx_cyc[3]  = '{0, 0, 0};
  int b_rx[3], b_pe[3], b_fe[3], b_bk[3], b_pex[3], b_bkx[3];

  // Counts high cycles of every pulse (so a 2-cycle pulse counts twice) and orphaned flags.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rx_v[i]) begin
        rx_cnt[i] <= rx_cnt[i] + 1;
        rx_cyc[i] <= cyc;
      end
      if (pe_v[i]) pe_cnt[i] <= pe_cnt[i] + 1;
      if (fe_v[i]) fe_cnt[i] <= fe_cnt[i] + 1;
      if (bk_v[i]) bk_cnt[i] <= bk_cnt[i] + 1;
      if (pe_v[i] && !rx_v[i]) pex_cnt[i] <= pex_cnt[i] + 1;
      if (bk_v[i] && !fe_v[i]) bkx_cnt[i] <= bkx_cnt[i] + 1;
    end
  end

  function automatic int dout(input int sel);
    case (sel)
      0:       return int'(if0.oData);
      1:       return int'(if1.oData);
      default: return int'(if2.oData);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic snap();
    for (int i = 0; i < 3; i++) begin
      b_rx[i] = rx_cnt[i];  b_pe[i] = pe_cnt[i];   b_fe[i] = fe_cnt[i];
      b_bk[i] = bk_cnt[i];  b_pex[i] = pex_cnt[i]; b_bkx[i] = bkx_cnt[i];
    end
  endtask

  task automatic check_pulses(input string tag, input int sel, input int erx, input int epe,
                              input int efe, input int ebk);
    check({tag, "_rx"}, rx_cnt[sel] - b_rx[sel], erx);
    check({tag, "_pe"}, pe_cnt[sel] - b_pe[sel], epe);
    check({tag, "_fe"}, fe_cnt[sel] - b_fe[sel], efe);
    check({tag, "_brk"}, bk_cnt[sel] - b_bk[sel], ebk);
    check({tag, "_orphan"}, (pex_cnt[sel] - b_pex[sel]) + (bkx_cnt[sel] - b_bkx[sel]), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bit period; optional 1-clock inverted glitch in the middle of the bit.
  task automatic hold_bit(input int sel, input logic v, input bit glitch);
    rxd[sel] = v;
    if (glitch) begin
      repeat (8) @(posedge clk);
      #1 rxd[sel] = ~v;
      @(posedge clk);
      #1 rxd[sel] = v;
      repeat (7) @(posedge clk);
    end else begin
      repeat (16) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_frame(input int sel, input int nbits, input logic [8:0] val,
                            input int npar, input logic pbit, input int nstop,
                            input logic [1:0] stopv, input int gbit);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    hold_bit(sel, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) hold_bit(sel, val[i], i == gbit);
    if (npar != 0) hold_bit(sel, pbit, 1'b0);
    for (int s = 0; s < nstop; s++) hold_bit(sel, stopv[s], 1'b0);
    rxd[sel] = 1'b1;
  endtask

  typedef struct {
    int         sel;
    int         nbits;
    logic [8:0] val;
    int         npar;
    logic       pbit;
    int         nstop;
    logic [1:0] stopv;
    int         exp_rx;
    logic [8:0] exp_data;
    int         exp_pe;
    int         exp_fe;
    int         exp_bk;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{0, 8, 9'h0A5, 0, 1'b0, 1, 2'b01, 1, 9'h0A5, 0, 0, 0};
    vecs[1]  = '{0, 8, 9'h000, 0, 1'b0, 1, 2'b01, 1, 9'h000, 0, 0, 0};
    vecs[2]  = '{0, 8, 9'h0FF, 0, 1'b0, 1, 2'b01, 1, 9'h0FF, 0, 0, 0};
    vecs[3]  = '{0, 8, 9'h03C, 0, 1'b0, 1, 2'b00, 0, 9'h0FF, 0, 1, 0};
    vecs[4]  = '{1, 7, 9'h041, 1, 1'b0, 1, 2'b01, 1, 9'h041, 0, 0, 0};
    vecs[5]  = '{1, 7, 9'h041, 1, 1'b1, 1, 2'b01, 1, 9'h041, 1, 0, 0};
    vecs[6]  = '{1, 7, 9'h07F, 1, 1'b1, 1, 2'b01, 1, 9'h07F, 0, 0, 0};
    vecs[7]  = '{1, 7, 9'h000, 1, 1'b0, 1, 2'b00, 0, 9'h07F, 0, 1, 1};
    vecs[8]  = '{2, 8, 9'h055, 0, 1'b0, 2, 2'b11, 1, 9'h055, 0, 0, 0};
    vecs[9]  = '{2, 8, 9'h055, 0, 1'b0, 2, 2'b01, 0, 9'h055, 0, 1, 0};
    vecs[10] = '{2, 8, 9'h0AA, 0, 1'b0, 2, 2'b10, 0, 9'h055, 0, 1, 0};

    rst_n = 1'b0;
    rxd   = 3'b111;
    idle(3);
    check("reset_dut0", int'({if0.oData, if0.oReceived, if0.oParityError, if0.oFrameError, if0.oBreak}), 0);
    check("reset_dut1", int'({if1.oData, if1.oReceived, if1.oParityError, if1.oFrameError, if1.oBreak}), 0);
    check("reset_dut2", int'({if2.oData, if2.oReceived, if2.oParityError, if2.oFrameError, if2.oBreak}), 0);
    rst_n = 1'b1;
    idle(20);

    for (int v = 0; v < 11; v++) begin
      snap();
      send_frame(vecs[v].sel, vecs[v].nbits, vecs[v].val, vecs[v].npar, vecs[v].pbit,
                 vecs[v].nstop, vecs[v].stopv, -1);
      idle(48);
      check_pulses($sformatf("v%0d", v), vecs[v].sel, vecs[v].exp_rx, vecs[v].exp_pe,
                   vecs[v].exp_fe, vecs[v].exp_bk);
      check($sformatf("v%0d_data", v), dout(vecs[v].sel), int'(vecs[v].exp_data));
    end

    // Latency from the start edge to oReceived, nominally 155 clocks here.
    snap();
    send_frame(0, 8, 9'h0A5, 0, 1'b0, 1, 2'b01, -1);
    idle(48);
    check("lat_rx", rx_cnt[0] - b_rx[0], 1);
    check("lat_window", ((rx_cyc[0] - start_cyc >= 148) && (rx_cyc[0] - start_cyc <= 160)) ? 1 : 0, 1);

    // Three-clock low glitch on an idle line is a false start.
    snap();
    rxd[0] = 1'b0;
    idle(3);
    rxd[0] = 1'b1;
    idle(64);
    check_pulses("glitch", 0, 0, 0, 0, 0);
    snap();
    send_frame(0, 8, 9'h096, 0, 1'b0, 1, 2'b01, -1);
    idle(48);
    check_pulses("after_glitch", 0, 1, 0, 0, 0);
    check("after_glitch_data", dout(0), 32'h96);

    // Break: 12 bit times low.
    snap();
    rxd[0] = 1'b0;
    idle(192);
    rxd[0] = 1'b1;
    idle(48);
    check_pulses("break", 0, 0, 0, 1, 1);
    check("break_data", dout(0), 32'h96);
    snap();
    send_frame(0, 8, 9'h03C, 0, 1'b0, 1, 2'b01, -1);
    idle(48);
    check_pulses("after_break", 0, 1, 0, 0, 0);
    check("after_break_data", dout(0), 32'h3C);

    // Reset during data bit 4 of 0xF3; bits 4..7 and stop are high so no new start follows.
    @(posedge clk);
    #1;
    hold_bit(0, 1'b0, 1'b0);
    hold_bit(0, 1'b1, 1'b0);
    hold_bit(0, 1'b1, 1'b0);
    hold_bit(0, 1'b0, 1'b0);
    hold_bit(0, 1'b0, 1'b0);
    rxd[0] = 1'b1;
    idle(6);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", int'({if0.oData, if0.oReceived, if0.oParityError, if0.oFrameError, if0.oBreak}), 0);
    idle(4);
    rst_n = 1'b1;
    snap();
    idle(6);
    for (int i = 0; i < 4; i++) hold_bit(0, 1'b1, 1'b0);
    idle(48);
    check_pulses("midreset_rest", 0, 0, 0, 0, 0);
    snap();
    send_frame(0, 8, 9'h081, 0, 1'b0, 1, 2'b01, -1);
    idle(48);
    check_pulses("after_reset", 0, 1, 0, 0, 0);
    check("after_reset_data", dout(0), 32'h81);

`ifdef SERIAL_RECEIVER_MAJORITY_VOTE_EN
    // One-clock glitch in the middle of data bit 2 is voted out.
    snap();
    send_frame(0, 8, 9'h0A5, 0, 1'b0, 1, 2'b01, 2);
    idle(48);
    check_pulses("vote_glitch", 0, 1, 0, 0, 0);
    check("vote_glitch_data", dout(0), 32'hA5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
